// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline-stage registers: control-bundle layout and
// skid-buffer occupancy state encodings.
package pipe_pkg;

    // Default width of the control bundle.
    localparam int CTRL_W_DEF = 6;

    // Bit positions inside the control bundle.
    localparam int CTRL_BRANCH  = 0;
    localparam int CTRL_JUMP    = 1;
    localparam int CTRL_MEMRD   = 2;
    localparam int CTRL_MEMWR   = 3;
    localparam int CTRL_REGWR   = 4;
    localparam int CTRL_MEM2REG = 5;

    // Occupancy of the stage: nothing held, main entry only, main plus skid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    // The stage can take a new word in every state except FULL.
    function automatic logic can_accept(input stage_state_e st);
        return (st != ST_FULL);
    endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating event counter with synchronous active-low reset. Stops at the
// all-ones value instead of wrapping so long stalls never read as short ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_r;

    // Count qualifying cycles, holding at the maximum value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (inc && (count_r != {CNT_W{1'b1}})) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline-stage register with valid/ready handshake and a 2-entry
// skid buffer. up_ready is registered so the upstream stage never sees a
// combinational path from dn_ready; the skid entry absorbs the one word that
// can arrive in the cycle the stage fills up. ctrl_out is forced to zero by
// loading zero into the main control register whenever the stage empties.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = 69,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  stall_cnt
);

    stage_state_e      state_r;
    stage_state_e      state_nxt_s;
    logic [CTRL_W-1:0] main_ctrl_r;
    logic [CTRL_W-1:0] main_ctrl_nxt_s;
    logic [DATA_W-1:0] main_data_r;
    logic [DATA_W-1:0] main_data_nxt_s;
    logic [CTRL_W-1:0] skid_ctrl_r;
    logic [CTRL_W-1:0] skid_ctrl_nxt_s;
    logic [DATA_W-1:0] skid_data_r;
    logic [DATA_W-1:0] skid_data_nxt_s;
    logic              up_ready_r;
    logic              dn_valid_r;
    logic              accept_s;
    logic              release_s;
    logic              stall_s;

    assign accept_s  = up_valid & up_ready_r;
    assign release_s = dn_valid_r & dn_ready;
    assign stall_s   = dn_valid_r & ~dn_ready;

    // Next occupancy and entry contents from the handshake; flush wins over both.
    always_comb begin
        state_nxt_s     = state_r;
        main_ctrl_nxt_s = main_ctrl_r;
        main_data_nxt_s = main_data_r;
        skid_ctrl_nxt_s = skid_ctrl_r;
        skid_data_nxt_s = skid_data_r;
        if (flush) begin
            // Drop everything; data_out keeps its last value.
            state_nxt_s     = ST_EMPTY;
            main_ctrl_nxt_s = {CTRL_W{1'b0}};
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_nxt_s     = ST_ONE;
                        main_ctrl_nxt_s = ctrl_in;
                        main_data_nxt_s = data_in;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && release_s) begin
                        state_nxt_s     = ST_ONE;
                        main_ctrl_nxt_s = ctrl_in;
                        main_data_nxt_s = data_in;
                    end else if (accept_s) begin
                        state_nxt_s     = ST_FULL;
                        skid_ctrl_nxt_s = ctrl_in;
                        skid_data_nxt_s = data_in;
                    end else if (release_s) begin
                        state_nxt_s     = ST_EMPTY;
                        main_ctrl_nxt_s = {CTRL_W{1'b0}};
                    end else begin
                        state_nxt_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (release_s) begin
                        state_nxt_s     = ST_ONE;
                        main_ctrl_nxt_s = skid_ctrl_r;
                        main_data_nxt_s = skid_data_r;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                default: begin
                    state_nxt_s     = ST_EMPTY;
                    main_ctrl_nxt_s = {CTRL_W{1'b0}};
                end
            endcase
        end
    end

    // State, entry registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= ST_EMPTY;
            main_ctrl_r <= {CTRL_W{1'b0}};
            main_data_r <= {DATA_W{1'b0}};
            skid_ctrl_r <= {CTRL_W{1'b0}};
            skid_data_r <= {DATA_W{1'b0}};
            up_ready_r  <= 1'b0;
            dn_valid_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            main_ctrl_r <= main_ctrl_nxt_s;
            main_data_r <= main_data_nxt_s;
            skid_ctrl_r <= skid_ctrl_nxt_s;
            skid_data_r <= skid_data_nxt_s;
            up_ready_r  <= can_accept(state_nxt_s);
            dn_valid_r  <= (state_nxt_s != ST_EMPTY);
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_s),
        .count (stall_cnt)
    );

    assign up_ready = up_ready_r;
    assign dn_valid = dn_valid_r;
    assign ctrl_out = main_ctrl_r;
    assign data_out = main_data_r;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, streaming, backpressure, flush,
// stall-counter saturation (CNT_W=4) and reset while full.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int CTRL_W = 6;
    localparam int DATA_W = 69;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              up_valid;
    logic              up_ready;
    logic [CTRL_W-1:0] ctrl_in;
    logic [DATA_W-1:0] data_in;
    logic              dn_valid;
    logic              dn_ready;
    logic [CTRL_W-1:0] ctrl_out;
    logic [DATA_W-1:0] data_out;
    logic [CNT_W-1:0]  stall_cnt;

    int checks = 0;
    int errors = 0;

    pipe_stage_skid #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .up_valid  (up_valid),
        .up_ready  (up_ready),
        .ctrl_in   (ctrl_in),
        .data_in   (data_in),
        .dn_valid  (dn_valid),
        .dn_ready  (dn_ready),
        .ctrl_out  (ctrl_out),
        .data_out  (data_out),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control pattern for word w: RegWrite always set, low bits vary with w.
    function automatic logic [CTRL_W-1:0] mkctrl(input int w);
        logic [CTRL_W-1:0] c;
        c = 6'd0;
        c[CTRL_REGWR]   = 1'b1;
        c[CTRL_BRANCH]  = w[0];
        c[CTRL_JUMP]    = w[1];
        c[CTRL_MEMRD]   = w[2];
        c[CTRL_MEMWR]   = w[3];
        c[CTRL_MEM2REG] = w[4];
        return c;
    endfunction

    // Data pattern for word w, spread over the whole bundle.
    function automatic logic [DATA_W-1:0] mkdata(input int w);
        logic [31:0] v;
        v = 32'(w);
        return {v[4:0], ~v, v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input int w);
        up_valid = 1'b1;
        ctrl_in  = mkctrl(w);
        data_in  = mkdata(w);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; dn_ready = 1'b0;
        offer(5);

        // 1. Reset held two cycles with an offer pending.
        tick(); tick();
        chk("rst_dn_valid", DATA_W'(dn_valid), 69'd0);
        chk("rst_ctrl", DATA_W'(ctrl_out), 69'd0);
        chk("rst_data", data_out, 69'd0);
        chk("rst_up_ready", DATA_W'(up_ready), 69'd0);
        chk("rst_stall", DATA_W'(stall_cnt), 69'd0);
        rst = 1'b1; up_valid = 1'b0;
        tick();
        chk("rel_up_ready", DATA_W'(up_ready), 69'd1);
        chk("rel_dn_valid", DATA_W'(dn_valid), 69'd0);

        // 2. Streaming 8 words with dn_ready=1.
        dn_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            offer(i);
            tick();
            chk("str_valid", DATA_W'(dn_valid), 69'd1);
            chk("str_data", data_out, mkdata(i));
            chk("str_ctrl", DATA_W'(ctrl_out), DATA_W'(mkctrl(i)));
            chk("str_up_ready", DATA_W'(up_ready), 69'd1);
        end
        up_valid = 1'b0;
        tick();
        chk("str_drain_valid", DATA_W'(dn_valid), 69'd0);
        chk("str_drain_ctrl", DATA_W'(ctrl_out), 69'd0);
        chk("str_drain_hold", data_out, mkdata(8));
        chk("str_stall", DATA_W'(stall_cnt), 69'd0);

        // 3. Backpressure: A=0xA, B=0xB accepted, C=0xC held off.
        dn_ready = 1'b0;
        offer(10); tick();
        chk("bp_a_valid", DATA_W'(dn_valid), 69'd1);
        chk("bp_a_ready", DATA_W'(up_ready), 69'd1);
        offer(11); tick();
        chk("bp_full_ready", DATA_W'(up_ready), 69'd0);
        chk("bp_full_data", data_out, mkdata(10));
        chk("bp_stall1", DATA_W'(stall_cnt), 69'd1);
        offer(12); tick();
        chk("bp_hold_ready", DATA_W'(up_ready), 69'd0);
        chk("bp_hold_data", data_out, mkdata(10));
        chk("bp_stall2", DATA_W'(stall_cnt), 69'd2);
        dn_ready = 1'b1; tick();
        chk("bp_out_b", data_out, mkdata(11));
        chk("bp_out_b_ctrl", DATA_W'(ctrl_out), DATA_W'(mkctrl(11)));
        chk("bp_ready_back", DATA_W'(up_ready), 69'd1);
        tick();
        chk("bp_out_c", data_out, mkdata(12));
        up_valid = 1'b0; tick();
        chk("bp_empty", DATA_W'(dn_valid), 69'd0);
        chk("bp_stall_keep", DATA_W'(stall_cnt), 69'd2);

        // 4. Flush while FULL with an offer pending (release completes that cycle).
        dn_ready = 1'b0;
        offer(13); tick();
        chk("fl_stall_d", DATA_W'(stall_cnt), 69'd2);
        offer(14); tick();
        chk("fl_full_ready", DATA_W'(up_ready), 69'd0);
        chk("fl_stall_e", DATA_W'(stall_cnt), 69'd3);
        offer(15); flush = 1'b1; dn_ready = 1'b1; tick();
        chk("fl_valid", DATA_W'(dn_valid), 69'd0);
        chk("fl_ctrl", DATA_W'(ctrl_out), 69'd0);
        chk("fl_ready", DATA_W'(up_ready), 69'd1);
        chk("fl_stall", DATA_W'(stall_cnt), 69'd3);
        chk("fl_data_hold", data_out, mkdata(13));
        flush = 1'b0; up_valid = 1'b0; tick();
        chk("fl_no_deliver", DATA_W'(dn_valid), 69'd0);

        // Flush in ONE discards a same-cycle accept; flush does not clear stall_cnt.
        dn_ready = 1'b0;
        offer(16); tick();
        chk("fl1_valid", DATA_W'(dn_valid), 69'd1);
        offer(17); flush = 1'b1; tick();
        chk("fl1_drop_valid", DATA_W'(dn_valid), 69'd0);
        chk("fl1_data_hold", data_out, mkdata(16));
        chk("fl1_stall", DATA_W'(stall_cnt), 69'd4);
        flush = 1'b0; up_valid = 1'b0; tick();
        chk("fl1_no_deliver", DATA_W'(dn_valid), 69'd0);

        // 5. Saturation of the 4-bit stall counter.
        offer(18); tick();
        up_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_15", DATA_W'(stall_cnt), 69'd15);
        chk("sat_data", data_out, mkdata(18));
        tick();
        chk("sat_hold", DATA_W'(stall_cnt), 69'd15);

        // 6. Reset while FULL.
        offer(19); tick();
        chk("rf_full", DATA_W'(up_ready), 69'd0);
        rst = 1'b0; tick();
        chk("rf_valid", DATA_W'(dn_valid), 69'd0);
        chk("rf_ctrl", DATA_W'(ctrl_out), 69'd0);
        chk("rf_data", data_out, 69'd0);
        chk("rf_ready", DATA_W'(up_ready), 69'd0);
        chk("rf_stall", DATA_W'(stall_cnt), 69'd0);
        rst = 1'b1; up_valid = 1'b0; tick();
        chk("rf_ready_back", DATA_W'(up_ready), 69'd1);
        chk("rf_still_empty", DATA_W'(dn_valid), 69'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
